// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the dual-clock FIFO pointer logic.
//   bin2gray     : binary -> reflected Gray code
//   gray2bin     : Gray -> binary (XOR-prefix from the MSB down)
//   full_pattern : the Gray value the write pointer has when the FIFO is full,
//                  given the read pointer's Gray value of width w
// Values are carried zero-extended in FIFO_MAX_W bits so one function serves
// every pointer width; callers size-cast the result back down.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_MAX_W = 64;

  typedef logic [FIFO_MAX_W-1:0] fifo_word_t;

  function automatic fifo_word_t bin2gray(input fifo_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic fifo_word_t gray2bin(input fifo_word_t g);
    fifo_word_t b;
    b = '0;
    b[FIFO_MAX_W-1] = g[FIFO_MAX_W-1];
    for (int i = FIFO_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full in Gray terms: the top two bits are inverted, the rest equal.
  // That is the Gray image of "same low bits, different wrap bit".
  function automatic fifo_word_t full_pattern(input fifo_word_t g,
                                              input int unsigned w);
    fifo_word_t mask;
    mask = fifo_word_t'(2'b11) << (w - 2);
    return g ^ mask;
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// -----------------------------------------------------------------------------
// bin_to_gray
// Purely combinational binary -> Gray converter.
//   i_bin  [W-1:0] binary value
//   o_gray [W-1:0] Gray value, o_gray = i_bin ^ (i_bin >> 1)
// -----------------------------------------------------------------------------
module bin_to_gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_to_binary.sv
// -----------------------------------------------------------------------------
// gray_to_binary
// Purely combinational Gray -> binary converter.
//   i_gray [W-1:0] Gray value
//   o_bin  [W-1:0] binary value
// Each binary bit is the XOR of all Gray bits at or above it, written per bit
// so there is no bit-to-bit combinational chain inside one vector.
// -----------------------------------------------------------------------------
module gray_to_binary #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

// File: rtl/fifo_wptr_gray.sv
// -----------------------------------------------------------------------------
// fifo_wptr_gray
// Write-side pointer generator for a dual-clock FIFO, entirely in clk's domain.
// Holds a PTR+1 bit binary write pointer, publishes it as a registered Gray
// code, and derives full / overflow / fill level from the already-synchronized
// read Gray pointer.
//
// Ports
//   clk          write-domain clock, rising edge
//   rst_n        synchronous active-low reset
//   wr_en        write request for this cycle
//   rd_gray_sync [PTR:0]   read pointer (Gray), already in clk's domain
//   wr_addr      [PTR-1:0] RAM write address for the current cycle
//   wr_gray      [PTR:0]   registered Gray write pointer
//   full         registered full flag
//   wr_overflow  one-cycle pulse after a refused write
//   wr_level     [PTR:0]   registered fill level, 0..2^PTR
//
// Handshake: wr_en is a request with no back-pressure wait. At a rising edge
// the write is taken (push) exactly when wr_en is high and the registered full
// is low; the data goes to the wr_addr visible before that edge. When full is
// high the request is dropped for good and wr_overflow pulses the next cycle.
//
// PTR must be >= 2 and PTR+1 must not exceed fifo_pkg::FIFO_MAX_W.
// -----------------------------------------------------------------------------
module fifo_wptr_gray
  import fifo_pkg::*;
#(
  parameter int PTR = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [PTR:0]   rd_gray_sync,
  output logic [PTR-1:0] wr_addr,
  output logic [PTR:0]   wr_gray,
  output logic           full,
  output logic           wr_overflow,
  output logic [PTR:0]   wr_level
);

  logic [PTR:0] r_wr_bin;
  logic [PTR:0] r_wr_gray;
  logic         r_full;
  logic         r_wr_overflow;
  logic [PTR:0] r_wr_level;

  logic         w_push;
  logic [PTR:0] w_wr_bin_next;
  logic [PTR:0] w_wr_gray_next;
  logic [PTR:0] w_rd_bin;
  logic [PTR:0] w_full_pat;

  assign w_push        = wr_en & ~r_full;
  // Natural PTR+1 bit overflow gives the modulo-2^(PTR+1) wrap.
  assign w_wr_bin_next = r_wr_bin + {{PTR{1'b0}}, w_push};

  bin_to_gray #(
    .W (PTR + 1)
  ) u_bin_to_gray (
    .i_bin  (w_wr_bin_next),
    .o_gray (w_wr_gray_next)
  );

  gray_to_binary #(
    .W (PTR + 1)
  ) u_gray_to_binary (
    .i_gray (rd_gray_sync),
    .o_bin  (w_rd_bin)
  );

  assign w_full_pat = (PTR + 1)'(full_pattern(fifo_word_t'(rd_gray_sync),
                                              PTR + 1));

  // Pointer group: binary and Gray move together so wr_gray is a pure flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
    end else begin
      r_wr_bin  <= w_wr_bin_next;
      r_wr_gray <= w_wr_gray_next;
    end
  end

  // Flag group: compares against the next pointer so the push that fills the
  // last slot raises full on its own edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full        <= 1'b0;
      r_wr_overflow <= 1'b0;
    end else begin
      r_full        <= (w_wr_gray_next == w_full_pat);
      r_wr_overflow <= wr_en & r_full;
    end
  end

  // Level group: modulo subtraction handles pointers on opposite wrap laps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_level <= '0;
    end else begin
      r_wr_level <= w_wr_bin_next - w_rd_bin;
    end
  end

  assign wr_addr     = r_wr_bin[PTR-1:0];
  assign wr_gray     = r_wr_gray;
  assign full        = r_full;
  assign wr_overflow = r_wr_overflow;
  assign wr_level    = r_wr_level;

endmodule

// File: tb/tb_fifo_wptr_gray.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_gray
// Directed bench for fifo_wptr_gray with PTR=3 (depth 8, 4-bit pointers).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_gray;

  localparam int PTR = 3;
  localparam int W   = PTR + 1;

  // clock / reset block
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           wr_en        = 1'b0;
  logic [W-1:0]   rd_gray_sync = '0;
  logic [PTR-1:0] wr_addr;
  logic [W-1:0]   wr_gray;
  logic           full;
  logic           wr_overflow;
  logic [W-1:0]   wr_level;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wptr_gray #(
    .PTR (PTR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_gray_sync (rd_gray_sync),
    .wr_addr      (wr_addr),
    .wr_gray      (wr_gray),
    .full         (full),
    .wr_overflow  (wr_overflow),
    .wr_level     (wr_level)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_gray_sync = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Reset overrides a pending write.
  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({wr_gray, wr_addr, full, wr_overflow, wr_level} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset: gray=%h addr=%h full=%b ovf=%b level=%h, required all 0",
               wr_gray, wr_addr, full, wr_overflow, wr_level);
    end
    wr_en = 1'b0;
    rst_n = 1'b1;
  endtask

  // Fill all 8 slots with the read pointer parked at 0.
  task automatic test_fill();
    logic [W-1:0] exp_gray [9];
    exp_gray = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    rd_gray_sync = '0;
    for (int i = 1; i <= 8; i++) begin
      logic [PTR-1:0] ea;
      ea = PTR'(i);
      wr_en = 1'b1;
      tick();
      n_tests++;
      if (wr_gray !== exp_gray[i] || wr_addr !== ea ||
          full !== (i == 8) || wr_level !== W'(i)) begin
        n_fail++;
        $display("FAIL fill[%0d]: gray=%h addr=%h full=%b level=%0d, required gray=%h addr=%h full=%b level=%0d",
                 i, wr_gray, wr_addr, full, wr_level, exp_gray[i], ea, (i == 8), i);
      end
    end
  endtask

  // Writes while full are refused, pointers frozen, one pulse per cycle.
  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      tick();
      n_tests++;
      if (wr_overflow !== 1'b1 || wr_addr !== 3'd0 || wr_gray !== 4'hC ||
          full !== 1'b1 || wr_level !== 4'd8) begin
        n_fail++;
        $display("FAIL overflow[%0d]: ovf=%b addr=%h gray=%h full=%b level=%0d, required 1 0 C 1 8",
                 i, wr_overflow, wr_addr, wr_gray, full, wr_level);
      end
    end
    wr_en = 1'b0;
    tick();
    n_tests++;
    if (wr_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_end: ovf=%b, required 0", wr_overflow);
    end
  endtask

  // Read side jumps to binary 4 (Gray 6); full drops, then one more push.
  task automatic test_drain_and_push();
    rd_gray_sync = 4'h6;
    tick();
    n_tests++;
    if (full !== 1'b0 || wr_level !== 4'd4 || wr_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: full=%b level=%0d ovf=%b, required 0 4 0",
               full, wr_level, wr_overflow);
    end
    push_n(1);
    n_tests++;
    if (wr_gray !== 4'hD || wr_addr !== 3'd1 || wr_level !== 4'd5 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_push: gray=%h addr=%h level=%0d full=%b, required D 1 5 0",
               wr_gray, wr_addr, wr_level, full);
    end
  endtask

  // 16 pushes, read pointer one step behind: wraps to 0, never full,
  // exactly one Gray bit toggles each push.
  task automatic test_wrap();
    logic [W-1:0] b;
    logic [W-1:0] eg;
    logic [W-1:0] prev;
    do_reset();
    b = '0;
    for (int k = 1; k <= 16; k++) begin
      prev = wr_gray;
      rd_gray_sync = b ^ (b >> 1);
      wr_en = 1'b1;
      tick();
      b = b + 1'b1;
      eg = b ^ (b >> 1);
      n_tests++;
      if (wr_gray !== eg || full !== 1'b0 || wr_level !== 4'd1 ||
          $countones(wr_gray ^ prev) != 1) begin
        n_fail++;
        $display("FAIL wrap[%0d]: gray=%h prev=%h full=%b level=%0d, required gray=%h full=0 level=1 one-bit step",
                 k, wr_gray, prev, full, wr_level, eg);
      end
    end
    wr_en = 1'b0;
    n_tests++;
    if (wr_gray !== 4'h0) begin
      n_fail++;
      $display("FAIL wrap_zero: gray=%h, required 0", wr_gray);
    end
  endtask

  // Push and read advance on the same edge at level 7.
  task automatic test_back_to_back();
    do_reset();
    push_n(7);
    n_tests++;
    if (wr_level !== 4'd7 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_setup: level=%0d full=%b, required 7 0", wr_level, full);
    end
    rd_gray_sync = 4'h1;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_tests++;
    if (wr_level !== 4'd7 || full !== 1'b0 || wr_gray !== 4'hC || wr_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b: level=%0d full=%b gray=%h addr=%h, required 7 0 C 0",
               wr_level, full, wr_gray, wr_addr);
    end
  endtask

  // Reset mid-stream with a write pending, then restart.
  task automatic test_mid_reset();
    do_reset();
    push_n(5);
    n_tests++;
    if (wr_level !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_setup: level=%0d, required 5", wr_level);
    end
    rst_n = 1'b0;
    wr_en = 1'b1;
    tick();
    n_tests++;
    if ({wr_gray, wr_addr, full, wr_overflow, wr_level} !== 13'd0) begin
      n_fail++;
      $display("FAIL mid_reset: gray=%h addr=%h full=%b ovf=%b level=%h, required all 0",
               wr_gray, wr_addr, full, wr_overflow, wr_level);
    end
    rst_n = 1'b1;
    tick();
    wr_en = 1'b0;
    n_tests++;
    if (wr_gray !== 4'h1 || wr_addr !== 3'd1 || wr_level !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_restart: gray=%h addr=%h level=%0d, required 1 1 1",
               wr_gray, wr_addr, wr_level);
    end
  endtask

  // sequence + final report
  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_and_push();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
